// File: rtl/sqrt_pkg.sv
// ============================================================================
// Module      : sqrt_pkg
// Description : Shared state encoding and parameter check for sqrt_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_t;

    // The operand is consumed two bits at a time, so it must be an even width.
    function automatic bit width_ok(input int width);
        return (width >= 4) && ((width % 2) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sqrt_seq_if.sv
// ============================================================================
// Module      : sqrt_seq_if
// Description : Operand/result handshake bundle for sqrt_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sqrt_seq_if #(
    parameter int WIDTH = 16
);
    localparam int RW = WIDTH / 2;

    logic            in_valid;
    logic            in_ready;
    logic [WIDTH-1:0] num;
    logic            round_en;
    logic            out_valid;
    logic            out_ready;
    logic [RW-1:0]   root;
    logic [RW:0]     rem;
    logic            busy;

    modport master (
        output in_valid, num, round_en, out_ready,
        input  in_ready, out_valid, root, rem, busy
    );

    modport slave (
        input  in_valid, num, round_en, out_ready,
        output in_ready, out_valid, root, rem, busy
    );

endinterface

`default_nettype wire

// File: rtl/sqrt_step.sv
// ============================================================================
// Module      : sqrt_step
// Description : One combinational digit-by-digit square-root iteration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_step #(
    parameter int RW = 8
) (
    input  wire logic [RW+1:0] r,
    input  wire logic [RW-1:0] q,
    input  wire logic [1:0]    pair,
    output logic      [RW+1:0] r_next,
    output logic      [RW-1:0] q_next
);

    logic [RW+1:0] w_r_shift;
    logic [RW+1:0] w_trial;
    logic          w_fit;
    logic [2:0]    w_unused;

    // The dropped high bits are always zero while iterating: the partial
    // remainder never exceeds twice the partial root.
    assign w_r_shift = {r[RW-1:0], pair};
    assign w_trial   = {q, 2'b01};
    assign w_fit     = (w_r_shift >= w_trial);
    assign w_unused  = {r[RW+1:RW], q[RW-1]};

    assign r_next = w_fit ? (w_r_shift - w_trial) : w_r_shift;
    assign q_next = {q[RW-2:0], w_fit};

endmodule

`default_nettype wire

// File: rtl/sqrt_seq.sv
// ============================================================================
// Module      : sqrt_seq
// Description : Multi-cycle integer square root, one root bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_seq
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    sqrt_seq_if.slave  bus
);

    localparam int RW = WIDTH / 2;
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;
    localparam logic [CW-1:0] c_cnt_init = CW'(RW - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_width_check
            $error("sqrt_seq: WIDTH must be even and >= 4, got %0d", WIDTH);
        end
    endgenerate

    sqrt_state_t      r_state;
    logic [WIDTH-1:0] r_num;
    logic             r_round;
    logic [RW+1:0]    r_r;
    logic [RW-1:0]    r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [RW-1:0]    r_root;
    logic [RW:0]      r_rem;

    logic [1:0]       w_pair;
    logic [RW+1:0]    w_r_next;
    logic [RW-1:0]    w_q_next;
    logic             w_round_up;
    logic [RW-1:0]    w_root_fin;

    assign w_pair = r_num[{r_cnt, 1'b0} +: 2];

    sqrt_step #(.RW(RW)) u_step (
        .r      (r_r),
        .q      (r_q),
        .pair   (w_pair),
        .r_next (w_r_next),
        .q_next (w_q_next)
    );

    // Nearest-rounding threshold: num >= q^2 + q + 1/4 reduces to rem > q.
    assign w_round_up = r_round && (w_r_next > {2'b00, w_q_next});
    assign w_root_fin = !w_round_up ? w_q_next :
                        (&w_q_next) ? w_q_next : (w_q_next + RW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_num       <= '0;
            r_round     <= 1'b0;
            r_r         <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_root      <= '0;
            r_rem       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_num      <= bus.num;
                        r_round    <= bus.round_en;
                        r_r        <= '0;
                        r_q        <= '0;
                        r_cnt      <= c_cnt_init;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_r <= w_r_next;
                    r_q <= w_q_next;
                    if (r_cnt == '0) begin
                        r_rem       <= w_r_next[RW:0];
                        r_root      <= w_root_fin;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.root      = r_root;
    assign bus.rem       = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_seq.sv
// ============================================================================
// Module      : tb_sqrt_seq
// Description : Directed and random checks of sqrt_seq at WIDTH 16 and 32.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sqrt_seq;

    logic clk;
    logic rst_n;
    int   vectors;
    int   fails;

    sqrt_seq_if #(.WIDTH(16)) bus16 ();
    sqrt_seq_if #(.WIDTH(32)) bus32 ();

    sqrt_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    sqrt_seq #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Floor square root by bisection on plain integers.
    function automatic longint isqrt(input longint n);
        longint lo = 0;
        longint hi = 65536;
        while (hi - lo > 1) begin
            longint mid = (lo + hi) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    function automatic longint ref_root(input longint n, input bit rnd, input longint maxr);
        longint q = isqrt(n);
        if (rnd && (n - q * q > q) && (q < maxr)) return q + 1;
        return q;
    endfunction

    task automatic op16(input logic [15:0] n, input logic rnd, input int stall);
        longint exp_root = ref_root(n, rnd, 255);
        longint exp_rem  = n - isqrt(n) * isqrt(n);
        int     lat = 0;
        check("in_ready_idle16", bus16.in_ready, 1);
        bus16.num = n; bus16.round_en = rnd; bus16.in_valid = 1'b1;
        bus16.out_ready = (stall == 0);
        @(posedge clk); #1;
        bus16.in_valid = 1'b0; bus16.num = 16'($urandom); bus16.round_en = ~rnd;
        check("busy_calc16", {bus16.busy, bus16.in_ready}, 2'b10);
        while (!bus16.out_valid && lat < 40) begin
            bus16.in_valid = lat[0];
            @(posedge clk); #1;
            lat++;
        end
        bus16.in_valid = 1'b0;
        check("latency16", lat, 8);
        check("root16", bus16.root, exp_root);
        check("rem16", bus16.rem, exp_rem);
        for (int s = 0; s < stall; s++) begin
            bus16.in_valid = 1'b1;
            @(posedge clk); #1;
            check("hold16", {bus16.out_valid, bus16.in_ready, 8'(bus16.root), 9'(bus16.rem)},
                  {1'b1, 1'b0, 8'(exp_root), 9'(exp_rem)});
        end
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        check("xfer16", {bus16.out_valid, bus16.in_ready, bus16.busy}, 3'b010);
        check("root_kept16", bus16.root, exp_root);
    endtask

    task automatic op32(input logic [31:0] n, input logic rnd);
        longint exp_root = ref_root(n, rnd, 65535);
        longint exp_rem  = n - isqrt(n) * isqrt(n);
        int     lat = 0;
        check("in_ready_idle32", bus32.in_ready, 1);
        bus32.num = n; bus32.round_en = rnd; bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0; bus32.num = $urandom;
        while (!bus32.out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency32", lat, 16);
        check("root32", bus32.root, exp_root);
        check("rem32", bus32.rem, exp_rem);
        if (!rnd) begin
            check("identity32", longint'(bus32.root) * longint'(bus32.root) + longint'(bus32.rem), n);
            check("rem_bound32", longint'(bus32.rem) <= 2 * longint'(bus32.root), 1);
        end
        @(posedge clk); #1;
        check("xfer32", {bus32.out_valid, bus32.in_ready}, 2'b01);
    endtask

    initial begin
        bit stale;
        vectors = 0;
        fails   = 0;
        rst_n   = 1'b0;
        bus16.in_valid = 1'b0; bus16.num = '0; bus16.round_en = 1'b0; bus16.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.num = '0; bus32.round_en = 1'b0; bus32.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset16", {bus16.out_valid, bus16.busy, 8'(bus16.root), 9'(bus16.rem)}, 19'd0);
        check("reset32", {bus32.out_valid, bus32.busy, bus32.root}, 18'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", {bus16.in_ready, bus32.in_ready}, 2'b11);

        op16(16'd0,     1'b0, 0);
        op16(16'd144,   1'b0, 0);
        op16(16'd99,    1'b0, 0);
        op16(16'd99,    1'b1, 0);
        op16(16'd90,    1'b1, 0);
        op16(16'd65535, 1'b1, 0);
        op16(16'd1024,  1'b0, 5);

        // Abort an operation three iterations in.
        bus16.num = 16'd4096; bus16.round_en = 1'b0; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_abort", bus16.busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset", {bus16.out_valid, bus16.busy, 8'(bus16.root), 9'(bus16.rem)}, 19'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_abort", {bus16.in_ready, bus16.busy, bus16.out_valid}, 3'b100);
        stale = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            stale |= bus16.out_valid;
        end
        check("no_stale_result", stale, 0);
        op16(16'd49, 1'b0, 0);

        for (int k = 0; k < 12; k++) op16(16'($urandom), 1'($urandom_range(0, 1)), 0);

        op32(32'hFFFF_FFFF, 1'b0);
        for (int k = 0; k < 6; k++) op32($urandom, 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
